ps2_frame_receiver: RTL

- sys_clk-domain PS/2 front end. Synchronizes and filters the raw ps2_clk/ps2_data pins and receives 11-bit device-to-host frames.
- Checks each frame's start, odd parity and stop bits, and flags malformed or stalled frames.
- Folds E0 (extended) and F0 (break) prefixes into single key events.
- Feeds the scancode display/strobe stage with one-cycle key_valid pulses, replacing its ps2_clk-domain shift register.

---
 rtl/ps2_frame_receiver.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_frame_receiver.sv
// rtl/ps2_frame_receiver.sv - PS/2 device-to-host frame receiver with glitch filter and E0/F0 key-event folding
module ps2_frame_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          pend_ext_q, pend_ext_d, pend_brk_q, pend_brk_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_ext_q, key_ext_d, key_break_q, key_break_d;
  logic          key_valid_q, key_valid_d;
  logic          fall;

  always_comb begin
    state_d      = state_q;
    clk_s1_d     = ps2_clk;
    clk_s2_d     = clk_s1_q;
    dat_s1_d     = ps2_data;
    dat_s2_d     = dat_s1_q;
    filt_d       = filt_q;
    filt_cnt_d   = filt_cnt_q;
    to_cnt_d     = to_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    pend_ext_d   = pend_ext_q;
    pend_brk_d   = pend_brk_q;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_break_d  = key_break_q;
    key_valid_d  = 1'b0;
    fall         = 1'b0;

    // Filtered clock follows the synced pin only after FILTER_LEN stable cycles
    if (clk_s2_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FILT_LAST) begin
      filt_cnt_d = '0;
      filt_d     = clk_s2_q;
      fall       = filt_q;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (fall && !dat_s2_q) begin
          state_d   = RECV;
          bit_cnt_d = 4'd1;
        end
      end
      RECV: begin
        if (fall) begin
          to_cnt_d = '0;
          if (bit_cnt_q == 4'd10) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            // shift_q holds data bits 0..7 and parity at bit 8
            if ((^shift_q) && dat_s2_q) begin
              byte_d       = shift_q[7:0];
              byte_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            shift_d   = {dat_s2_q, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = IDLE;
          bit_cnt_d   = 4'd0;
          to_cnt_d    = '0;
          frame_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (byte_valid_q) begin
      if (byte_q == 8'hE0) begin
        pend_ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        pend_brk_d = 1'b1;
      end else begin
        key_code_d  = byte_q;
        key_ext_d   = pend_ext_q;
        key_break_d = pend_brk_q;
        key_valid_d = 1'b1;
        pend_ext_d  = 1'b0;
        pend_brk_d  = 1'b0;
      end
    end
    if (frame_err_q) begin
      pend_ext_d = 1'b0;
      pend_brk_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      to_cnt_q     <= '0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 9'd0;
      byte_q       <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      pend_ext_q   <= 1'b0;
      pend_brk_q   <= 1'b0;
      key_code_q   <= 8'd0;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      key_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      to_cnt_q     <= to_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      pend_ext_q   <= pend_ext_d;
      pend_brk_q   <= pend_brk_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
      key_valid_q  <= key_valid_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign key_code   = key_code_q;
  assign key_ext    = key_ext_q;
  assign key_break  = key_break_q;
  assign key_valid  = key_valid_q;
  assign busy       = (state_q == RECV);

endmodule
